// File: rtl/vc_fifo_bank.sv
// vc_fifo_bank: bank of independent virtual-channel FIFOs behind one write port and one registered read port,
// with per-channel status flags and sticky overflow/underflow errors.
module vc_fifo_bank #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4,
    parameter int VC_BITS = 1,
    localparam int NUM_VC = 2**VC_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  wr_enable,
    input  logic [VC_BITS-1:0]    wr_vc,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_enable,
    input  logic [VC_BITS-1:0]    rd_vc,
    input  logic [ADDR_WIDTH-1:0] umbral_full,
    input  logic [ADDR_WIDTH-1:0] umbral_empty,
    output logic [NUM_VC-1:0]     full,
    output logic [NUM_VC-1:0]     empty,
    output logic [NUM_VC-1:0]     almost_full,
    output logic [NUM_VC-1:0]     almost_empty,
    output logic [NUM_VC-1:0]     error,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [VC_BITS-1:0]    data_out_vc
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [NUM_VC][DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr [NUM_VC];
    logic [ADDR_WIDTH-1:0] rd_ptr [NUM_VC];
    logic [ADDR_WIDTH:0]   cnt [NUM_VC];
    logic                  wr_acc, rd_acc, ovf, unf;
    logic [NUM_VC-1:0]     wr_hit, rd_hit, err_hit;

    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            full[i]         = cnt[i] == CNT_FULL;
            empty[i]        = cnt[i] == '0;
            almost_full[i]  = cnt[i] >= CNT_FULL - {1'b0, umbral_full} && cnt[i] != CNT_FULL;
            almost_empty[i] = cnt[i] <= {1'b0, umbral_empty} && cnt[i] != '0;
        end
    end

    // A full channel still takes a write when the same channel is drained in that cycle.
    always_comb begin
        rd_acc = rd_enable && !empty[rd_vc];
        wr_acc = wr_enable && (!full[wr_vc] || (rd_enable && wr_vc == rd_vc));
        ovf    = wr_enable && !wr_acc;
        unf    = rd_enable && empty[rd_vc];
        for (int i = 0; i < NUM_VC; i++) begin
            wr_hit[i]  = wr_acc && wr_vc == VC_BITS'(i);
            rd_hit[i]  = rd_acc && rd_vc == VC_BITS'(i);
            err_hit[i] = (ovf && wr_vc == VC_BITS'(i)) || (unf && rd_vc == VC_BITS'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (init && wr_acc)
            mem[wr_vc][wr_ptr[wr_vc]] <= data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_VC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            error       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            data_out_vc <= '0;
        end else if (!init) begin
            for (int i = 0; i < NUM_VC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            error       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            data_out_vc <= '0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                if (wr_hit[i])
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (rd_hit[i])
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                cnt[i] <= (wr_hit[i] && !rd_hit[i]) ? cnt[i] + 1'b1 :
                          (rd_hit[i] && !wr_hit[i]) ? cnt[i] - 1'b1 : cnt[i];
            end
            error       <= error | err_hit;
            data_out    <= rd_acc ? mem[rd_vc][rd_ptr[rd_vc]] : '0;
            data_valid  <= rd_acc;
            data_out_vc <= rd_acc ? rd_vc : '0;
        end
    end
endmodule

// File: tb/tb_vc_fifo_bank.sv
// tb_vc_fifo_bank: directed self-checking bench for vc_fifo_bank (6-bit data, depth 4, two channels).
module tb_vc_fifo_bank;
    logic       clk = 1'b0;
    logic       reset, init, wr_enable, rd_enable;
    logic       wr_vc, rd_vc, data_out_vc, data_valid;
    logic [5:0] data_in, data_out;
    logic [1:0] umbral_full, umbral_empty;
    logic [1:0] full, empty, almost_full, almost_empty, error;
    int         n_pass = 0, n_total = 0;

    vc_fifo_bank #(.DATA_WIDTH(6), .ADDR_WIDTH(2), .VC_BITS(1)) dut (
        .clk(clk), .reset(reset), .init(init),
        .wr_enable(wr_enable), .wr_vc(wr_vc), .data_in(data_in),
        .rd_enable(rd_enable), .rd_vc(rd_vc),
        .umbral_full(umbral_full), .umbral_empty(umbral_empty),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .error(error), .data_out(data_out), .data_valid(data_valid), .data_out_vc(data_out_vc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic cyc(input logic we, input logic wv, input logic [5:0] d, input logic re, input logic rv);
        wr_enable = we;
        wr_vc     = wv;
        data_in   = d;
        rd_enable = re;
        rd_vc     = rv;
        @(posedge clk);
        #1;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic [5:0] d, input logic v);
        check({tag, "_valid"}, data_valid, 1);
        check({tag, "_data"}, data_out, d);
        check({tag, "_vc"}, data_out_vc, v);
    endtask

    task automatic pulse_init();
        init = 1'b0;
        @(posedge clk);
        #1;
        init = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; init = 1'b1; wr_enable = 1'b0; rd_enable = 1'b0;
        wr_vc = 1'b0; rd_vc = 1'b0; data_in = '0; umbral_full = '0; umbral_empty = '0;
        #3;
        check("rst_data", data_out, 0);
        check("rst_valid", data_valid, 0);
        check("rst_vc", data_out_vc, 0);
        check("rst_error", error, 0);
        check("rst_empty", empty, 2'b11);
        check("rst_full", full, 0);
        check("rst_af", almost_full, 0);
        check("rst_ae", almost_empty, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0);
        check("idle_empty", empty, 2'b11);
        check("idle_valid", data_valid, 0);
        check("idle_error", error, 0);

        // fill and drain VC1
        for (int i = 1; i <= 4; i++) cyc(1, 1, 6'(i), 0, 0);
        check("fill_full", full, 2'b10);
        check("fill_empty", empty, 2'b01);
        check("fill_af", almost_full, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 0, 1, 1);
            check_read($sformatf("drain%0d", i), 6'(i), 1);
        end
        check("drain_empty", empty, 2'b11);
        cyc(0, 0, 0, 0, 0);
        check("after_valid", data_valid, 0);
        check("after_data", data_out, 0);

        // overflow, underflow, init clear
        for (int i = 0; i < 4; i++) cyc(1, 0, 6'(8'h11 + i), 0, 0);
        cyc(1, 0, 6'h15, 0, 0);
        check("ovf_error", error, 2'b01);
        check("ovf_full", full, 2'b01);
        cyc(0, 0, 0, 1, 1);
        check("unf_error", error, 2'b11);
        check("unf_valid", data_valid, 0);
        pulse_init();
        check("init_error", error, 0);
        check("init_empty", empty, 2'b11);

        // simultaneous read/write on full then empty channel
        for (int i = 0; i < 4; i++) cyc(1, 0, 6'(8'h21 + i), 0, 0);
        cyc(1, 0, 6'h25, 1, 0);
        check_read("simfull", 6'h21, 0);
        check("simfull_full", full, 2'b01);
        check("simfull_error", error, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, 0);
            check_read($sformatf("tail%0d", i), 6'(8'h22 + i), 0);
        end
        check("tail_empty", empty, 2'b11);
        cyc(1, 0, 6'h26, 1, 0);
        check("simempty_error", error, 2'b01);
        check("simempty_valid", data_valid, 0);
        check("simempty_empty", empty, 2'b10);
        cyc(0, 0, 0, 1, 0);
        check_read("simempty_rd", 6'h26, 0);
        pulse_init();

        // thresholds and wrap-around
        umbral_full = 2'd1;
        umbral_empty = 2'd1;
        cyc(1, 0, 6'h31, 0, 0);
        check("thr1_ae", almost_empty, 2'b01);
        cyc(1, 0, 6'h32, 0, 0);
        check("thr2_ae", almost_empty, 0);
        check("thr2_af", almost_full, 0);
        cyc(1, 0, 6'h33, 0, 0);
        check("thr3_af", almost_full, 2'b01);
        umbral_full = 2'd0;
        #1;
        check("thr3_af_thr0", almost_full, 0);
        umbral_full = 2'd1;
        cyc(0, 0, 0, 1, 0);
        check_read("thrrd1", 6'h31, 0);
        cyc(0, 0, 0, 1, 0);
        check_read("thrrd2", 6'h32, 0);
        check("thr1b_ae", almost_empty, 2'b01);
        check("thr1b_af", almost_full, 0);
        for (int k = 0; k < 10; k++) begin
            cyc(1, 0, 6'(8'h08 + k), 1, 0);
            check_read($sformatf("wrap%0d", k), (k == 0) ? 6'h33 : 6'(8'h08 + k - 1), 0);
        end
        check("wrap_ae", almost_empty, 2'b01);
        cyc(0, 0, 0, 1, 0);
        check_read("wrap_last", 6'h11, 0);
        check("wrap_empty", empty, 2'b11);

        // interleave channels, then async reset between edges
        cyc(1, 0, 6'h2A, 0, 0);
        check("il1_empty", empty, 2'b10);
        cyc(1, 1, 6'h15, 1, 0);
        check_read("il2", 6'h2A, 0);
        check("il2_empty", empty, 2'b01);
        cyc(1, 0, 6'h0B, 1, 1);
        check_read("il3", 6'h15, 1);
        check("il3_empty", empty, 2'b10);
        cyc(1, 1, 6'h0C, 1, 0);
        check_read("il4", 6'h0B, 0);
        check("il4_empty", empty, 2'b01);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", data_valid, 0);
        check("arst_data", data_out, 0);
        check("arst_vc", data_out_vc, 0);
        check("arst_empty", empty, 2'b11);
        #2;
        reset = 1'b1;
        cyc(1, 1, 6'h3C, 0, 0);
        check("post_empty", empty, 2'b01);
        cyc(0, 0, 0, 1, 1);
        check_read("post_rd", 6'h3C, 1);
        check("post_error", error, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
